irq_nest_ctrl: RTL and testbench
================================

# irq_nest_ctrl

Nested three-level interrupt controller that sequences the CPU's PC redirection on interrupt entry and return. It latches interrupt requests, arbitrates by fixed priority against the level currently in service, and saves and restores return addresses on a 3-deep LIFO. On each entry or return it issues a one-cycle redirect (`redirect_valid`/`redirect_pc`) to the PC-select logic, which overrides the sequential/branch/jump next-PC.

## Interface

Parameters:
- `VEC1`, default 32'h0000_3038: handler entry address, level 1 (lowest priority).
- `VEC2`, default 32'h0000_3070: handler entry address, level 2.
- `VEC3`, default 32'h0000_30a8: handler entry address, level 3 (highest priority).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `irq` in 3: level request lines; bit 0 = level 1, bit 2 = level 3.
- `int_en` in 1: global enable for taking new interrupts; does not affect returns.
- `eret` in 1: one-cycle pulse when a handler-return instruction retires.
- `pc_cur` in 32: return address, i.e. the next instruction the program would execute.
- `redirect_valid` out 1: one-cycle strobe; next PC must be `redirect_pc`.
- `redirect_pc` out 32: vector address or restored return address.
- `in_service` out 3: levels currently entered and not yet returned.
- `pending` out 3: latched, not-yet-taken requests.
- `depth` out 2: LIFO occupancy, 0–3.
- `ret_err` out 1: one-cycle strobe when `eret` arrives with `depth` = 0.

## Operation

- **Request edge detect:** `irq` is registered into `irq_q`. When `irq[i] & ~irq_q[i]`, `pending[i]` is set.
  - A request that is already pending stays pending; repeated edges are not counted.
  - A level held high does not re-trigger.
- **Current level** = index of the highest set `in_service` bit, or 0 if none.
- **Take condition** (evaluated in state RUN, when no eret is pending): `int_en` = 1 and the highest set pending level is above the current level. On take:
  - push `pc_cur`;
  - set that level's `in_service` bit and clear its `pending` bit;
  - set `redirect_pc` to the vector for that level and pulse `redirect_valid`.
- **Return** (in RUN, when eret is pending or `eret` = 1, and `depth` > 0):
  - pop the LIFO into `redirect_pc` and pulse `redirect_valid`;
  - clear the highest set `in_service` bit.
- **Return with `depth` = 0:** pulse `ret_err`; no redirect and no state change.
- **Return and take in the same cycle:** the return wins. The pending request is re-evaluated at the next RUN edge against the lowered level.
- **Same-level or lower requests** stay pending until the current level drops below them.
- **LIFO overflow cannot occur:** strict priority limits nesting to depth 3. A push at `depth` = 3 is a design error and is flagged by an assertion.
- **FSM:**
  - RUN: decision state.
  - Every redirect moves to HOLD for exactly one cycle, then returns to RUN. No take or return is decided in HOLD.
  - An `eret` arriving during HOLD sets the one-entry `eret_pend` flag. That flag is serviced at the next RUN edge and cleared when serviced.
- **Reset values:**
  - all outputs 0; `redirect_pc` = 0;
  - `irq_q`, `pending`, `in_service`, LIFO and `eret_pend` cleared;
  - state RUN.
  - Because `irq_q` is cleared, `irq` high at reset release is treated as an edge.
- **Reset mid-operation:** all nesting context is discarded immediately. No redirect is issued on reset.

## Timing

- Edge E0 samples `irq[i]` = 1 with `irq_q[i]` = 0. `pending[i]` is high after E0.
- E1 (RUN): the decision edge. `pc_cur` is sampled at E1; `redirect_valid`, `redirect_pc`, `in_service` and `depth` update after E1, and `pending[i]` is cleared. Entry latency from request edge to redirect is 2 cycles.
- E2: HOLD→RUN; `redirect_valid` drops. The earliest next decision is at E3.
- `eret` sampled at edge En in RUN: the redirect is visible after En (latency 1). `eret` sampled in HOLD: serviced one edge later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure

- **Shared package `irq_pkg`:**
  - `lvl_t` (2-bit level, 0 = none);
  - `state_t` {RUN, HOLD};
  - default vector constants;
  - `DEPTH` = 3.
- **Sub-module `pc_lifo`:** 3×32 register stack.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top of stack), `depth`.
  - Asynchronous reset.
  - Simultaneous `push` and `pop` is illegal; the controller guarantees it never occurs.

## Test plan

- Single entry/return: `pc_cur`=0x100, pulse `irq[0]` → redirect to 0x3038 two cycles after the edge, `in_service`=001; `eret` → redirect to 0x100, `in_service`=000, `depth`=0.
- Full nesting: enter level 1 (pc 0x100), then `irq[1]` (pc 0x3040), then `irq[2]` (pc 0x3078) → vectors 0x3038, 0x3070, 0x30a8, `depth`=3; three `eret` pulses → 0x3078, 0x3040, 0x100 in that order.
- Priority blocking: in service at level 3, pulse `irq[0]` → `pending`=001, no redirect; `eret` → return redirect, then 0x3038 on the next RUN decision.
- Simultaneous events: `irq[2]` pending and `eret` in the same RUN cycle at level 1 → return wins; 0x30a8 is taken next.
- `int_en`=0: `irq[1]` edge → `pending`=010, no redirect; raise `int_en` → redirect to 0x3070.
- Boundary and reset: `eret` at `depth` 0 → `ret_err` pulse, nothing else changes; `eret` during HOLD is serviced one cycle later; assert `rst` at `depth` 2 → all outputs 0 immediately, no redirect.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared types, default vectors and level helpers for the nested interrupt controller
package irq_pkg;
  typedef logic [1:0] lvl_t;
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [31:0] VEC1_DEF = 32'h0000_3038;
  localparam logic [31:0] VEC2_DEF = 32'h0000_3070;
  localparam logic [31:0] VEC3_DEF = 32'h0000_30a8;
  localparam int DEPTH = 3;
  function automatic lvl_t hi_lvl(input logic [2:0] v);
    return v[2] ? 2'd3 : v[1] ? 2'd2 : v[0] ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [2:0] onehot(input lvl_t l);
    return l == 2'd3 ? 3'b100 : l == 2'd2 ? 3'b010 : l == 2'd1 ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/pc_lifo.sv
// pc_lifo: 3-deep return-address stack; dout shows the top entry
module pc_lifo
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [1:0]  depth
);
  logic [31:0] stack [DEPTH];
  assign dout = depth == 2'd0 ? 32'h0 : stack[depth - 2'd1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      depth <= 2'd0;
      stack <= '{default: '0};
    end else if (push) begin
      stack[depth] <= din;
      depth <= depth + 2'd1;
    end else if (pop)
      depth <= depth - 2'd1;
  // strict priority bounds nesting, so a full push or push+pop means the controller is broken
  always_ff @(posedge clk)
    assert (!(push && (depth == 2'd3 || pop)));
endmodule

// File: rtl/irq_nest_ctrl.sv
// irq_nest_ctrl: three-level nested interrupt controller issuing PC redirects on entry and return
module irq_nest_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] VEC1 = VEC1_DEF,
  parameter logic [31:0] VEC2 = VEC2_DEF,
  parameter logic [31:0] VEC3 = VEC3_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq,
  input  logic        int_en,
  input  logic        eret,
  input  logic [31:0] pc_cur,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [2:0]  in_service,
  output logic [2:0]  pending,
  output logic [1:0]  depth,
  output logic        ret_err
);
  state_t state, state_n;
  logic [2:0] irq_q;
  logic eret_pend, ret_req, take, ret, err;
  logic [31:0] top, vec;
  lvl_t lvl_p, lvl_c;
  assign lvl_p = hi_lvl(pending);
  assign lvl_c = hi_lvl(in_service);
  assign vec = lvl_p == 2'd3 ? VEC3 : lvl_p == 2'd2 ? VEC2 : VEC1;
  pc_lifo u_lifo (
    .clk(clk), .rst(rst), .push(take), .pop(ret),
    .din(pc_cur), .dout(top), .depth(depth)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  // a return always beats a take; the take is re-evaluated at the next RUN edge
  always_comb begin
    ret_req = eret | eret_pend;
    ret = state == RUN && ret_req && depth != 2'd0;
    err = state == RUN && ret_req && depth == 2'd0;
    take = state == RUN && !ret_req && int_en && lvl_p > lvl_c;
    state_n = (ret || take) ? HOLD : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_q <= 3'b0;
      pending <= 3'b0;
      in_service <= 3'b0;
      eret_pend <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= 32'h0;
      ret_err <= 1'b0;
    end else begin
      irq_q <= irq;
      pending <= (pending & ~(take ? onehot(lvl_p) : 3'b0)) | (irq & ~irq_q);
      in_service <= take ? in_service | onehot(lvl_p) : ret ? in_service & ~onehot(lvl_c) : in_service;
      eret_pend <= state == HOLD ? (eret_pend | eret) : 1'b0;
      redirect_valid <= ret | take;
      redirect_pc <= ret ? top : take ? vec : redirect_pc;
      ret_err <= err;
    end
endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb_irq_nest_ctrl: directed scenarios with a redirect scoreboard checked by an independent monitor
module tb_irq_nest_ctrl;
  logic clk = 0, rst = 1, int_en = 1, eret = 0;
  logic [2:0] irq = 0;
  logic [31:0] pc_cur = 0;
  logic redirect_valid, ret_err;
  logic [31:0] redirect_pc;
  logic [2:0] in_service, pending;
  logic [1:0] depth;
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];

  irq_nest_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .int_en(int_en), .eret(eret), .pc_cur(pc_cur),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_service(in_service),
    .pending(pending), .depth(depth), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk)
    if (!rst && redirect_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL redirect: unexpected pc=%h", redirect_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (redirect_pc !== e) begin
          fails++;
          $display("FAIL redirect: got %h expected %h", redirect_pc, e);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic raise(input logic [2:0] bits, input logic [31:0] pc, input logic tk);
    @(negedge clk); pc_cur = pc; irq = bits;
    @(negedge clk); irq = 0;
    chk("latency_early", redirect_valid, 0);
    @(negedge clk);
    chk("latency_take", redirect_valid, tk);
    @(negedge clk);
  endtask

  task automatic do_eret();
    @(negedge clk); eret = 1;
    @(negedge clk); eret = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_state", {in_service, pending, depth, ret_err}, 0);
    rst = 0;
    // single entry / return
    exp_q.push_back(32'h3038);
    raise(3'b001, 32'h100, 1);
    chk("s1_is", in_service, 3'b001);
    chk("s1_depth", depth, 1);
    exp_q.push_back(32'h100);
    do_eret();
    chk("s1_is_ret", in_service, 0);
    chk("s1_depth_ret", depth, 0);
    // full nesting
    exp_q.push_back(32'h3038); raise(3'b001, 32'h100, 1);
    exp_q.push_back(32'h3070); raise(3'b010, 32'h3040, 1);
    exp_q.push_back(32'h30a8); raise(3'b100, 32'h3078, 1);
    chk("s2_depth", depth, 3);
    chk("s2_is", in_service, 3'b111);
    exp_q.push_back(32'h3078); do_eret();
    exp_q.push_back(32'h3040); do_eret();
    exp_q.push_back(32'h100);  do_eret();
    chk("s2_depth_ret", depth, 0);
    // priority blocking
    exp_q.push_back(32'h30a8); raise(3'b100, 32'h200, 1);
    raise(3'b001, 32'h210, 0);
    chk("s3_pend", pending, 3'b001);
    chk("s3_is", in_service, 3'b100);
    exp_q.push_back(32'h200); exp_q.push_back(32'h3038);
    do_eret();
    repeat (2) @(negedge clk);
    chk("s3_is_after", in_service, 3'b001);
    chk("s3_pend_after", pending, 0);
    exp_q.push_back(32'h210); do_eret();
    // return and take in the same RUN cycle
    exp_q.push_back(32'h3038); raise(3'b001, 32'h300, 1);
    pc_cur = 32'h400;
    exp_q.push_back(32'h300); exp_q.push_back(32'h30a8);
    @(negedge clk); irq = 3'b100;
    @(negedge clk); irq = 0; eret = 1;
    @(negedge clk); eret = 0;
    chk("s4_is_mid", in_service, 0);
    repeat (3) @(negedge clk);
    chk("s4_is", in_service, 3'b100);
    chk("s4_depth", depth, 1);
    exp_q.push_back(32'h400); do_eret();
    // interrupts disabled
    int_en = 0;
    raise(3'b010, 32'h500, 0);
    chk("s5_pend", pending, 3'b010);
    exp_q.push_back(32'h3070);
    @(negedge clk); int_en = 1;
    @(negedge clk);
    @(negedge clk);
    chk("s5_is", in_service, 3'b010);
    exp_q.push_back(32'h500); do_eret();
    // return with empty stack
    @(negedge clk); eret = 1;
    @(negedge clk); eret = 0;
    chk("s6_err", ret_err, 1);
    chk("s6_state", {in_service, pending, depth}, 0);
    @(negedge clk);
    chk("s6_err_drop", ret_err, 0);
    // eret during HOLD
    exp_q.push_back(32'h3038); exp_q.push_back(32'h600);
    @(negedge clk); pc_cur = 32'h600; irq = 3'b001;
    @(negedge clk); irq = 0;
    @(negedge clk); eret = 1;
    @(negedge clk); eret = 0;
    chk("s7_rv_drop", redirect_valid, 0);
    chk("s7_is_hold", in_service, 3'b001);
    @(negedge clk);
    chk("s7_rv", redirect_valid, 1);
    chk("s7_is", in_service, 0);
    @(negedge clk);
    // reset at depth 2
    exp_q.push_back(32'h3038); raise(3'b001, 32'h700, 1);
    exp_q.push_back(32'h3070); raise(3'b010, 32'h710, 1);
    chk("s8_depth", depth, 2);
    @(negedge clk); rst = 1;
    #1;
    chk("s8_rst", {redirect_valid, redirect_pc, in_service, pending, depth, ret_err}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("s8_after", {redirect_valid, in_service, pending, depth, ret_err}, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
